// File: rtl/uart_pkg.sv
// uart_pkg: shared UART states, oversampling constants and divider helper
package uart_pkg;
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP, WAIT_HIGH} uart_state_e;
  localparam int OS_RATE = 16;
  localparam int SAMPLE_MID = 8;
  function automatic int os_div(input int clk_freq, input int baud);
    return clk_freq / (baud * OS_RATE);
  endfunction
endpackage

// File: rtl/uart_rx_os_if.sv
// uart_rx_os_if: serial line plus byte-side valid/ready handshake of the receiver
interface uart_rx_os_if;
  logic       rx;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       rx_ready;
  logic       frame_err;
  logic       parity_err;
  logic       overrun;
  logic       busy;
  modport master (input rx, rx_ready, output rx_data, rx_valid, frame_err, parity_err, overrun, busy);
  modport slave (output rx, rx_ready, input rx_data, rx_valid, frame_err, parity_err, overrun, busy);
endinterface

// File: rtl/uart_baud_tick.sv
// uart_baud_tick: oversample divider; clr_i holds the count at 0, tick_o pulses on the last count
module uart_baud_tick #(
  parameter int DIV = 10
) (
  input  logic clk,
  input  logic rst,
  input  logic clr_i,
  output logic tick_o
);
  localparam int W = DIV > 1 ? $clog2(DIV) : 1;
  logic [W-1:0] cnt_q, cnt_d;
  assign tick_o = !clr_i && cnt_q == W'(DIV - 1);
  assign cnt_d = (clr_i || tick_o) ? '0 : cnt_q + 1'b1;
  always_ff @(posedge clk) begin
    if (rst) cnt_q <= '0;
    else cnt_q <= cnt_d;
  end
endmodule

// File: rtl/uart_rx_os.sv
// uart_rx_os: 16x-oversampling UART receiver with majority vote, false-start rejection,
// optional parity, framing/break detection and a valid/ready output with overrun pulse
module uart_rx_os
  import uart_pkg::*;
#(
  parameter int CLK_FREQ   = 100_000_000,
  parameter int BAUD       = 9600,
  parameter int DATA_BITS  = 8,
  parameter int PARITY_EN  = 0,
  parameter int PARITY_ODD = 0,
  parameter int OS_DIV     = os_div(CLK_FREQ, BAUD)
) (
  input logic          clk,
  input logic          rst,
  uart_rx_os_if.master bus
);
  localparam logic [2:0] S_IDLE = IDLE;
  localparam logic [2:0] S_START = START;
  localparam logic [2:0] S_DATA = DATA;
  localparam logic [2:0] S_PARITY = PARITY;
  localparam logic [2:0] S_STOP = STOP;
  localparam logic [2:0] S_WAIT = WAIT_HIGH;

  if (OS_DIV < 2) begin : g_div_chk
    $error("uart_rx_os: OS_DIV must be >= 2");
  end
  if (DATA_BITS < 5 || DATA_BITS > 8) begin : g_bits_chk
    $error("uart_rx_os: DATA_BITS must be 5..8");
  end

  logic       meta_q, rxs_q;
  logic [2:0] state_q, state_d;
  logic [3:0] s_q, s_d, s_nxt;
  logic [2:0] bit_q, bit_d;
  logic [1:0] samp_q, samp_d;
  logic [7:0] shift_q, shift_d, data_w;
  logic       par_q, par_d;
  logic [7:0] rx_data_q, rx_data_d;
  logic       rx_valid_q, rx_valid_d, frame_err_q, frame_err_d;
  logic       parity_err_q, parity_err_d, overrun_q, overrun_d;
  logic       tick, win, mid, last, maj, deliver, load;

  uart_baud_tick #(.DIV(OS_DIV)) u_tick (
    .clk   (clk),
    .rst   (rst),
    .clr_i (state_q == S_IDLE && rxs_q),
    .tick_o(tick)
  );

  // s_nxt is the count this tick moves to; samples land on ticks reaching 7, 8 and 9
  assign s_nxt = s_q + 4'd1;
  assign win = tick && s_nxt >= 4'(SAMPLE_MID - 1) && s_nxt <= 4'(SAMPLE_MID + 1);
  assign mid = tick && s_nxt == 4'(SAMPLE_MID + 1);
  assign last = tick && s_q == 4'(OS_RATE - 1);
  assign maj = (samp_q[1] & samp_q[0]) | ((samp_q[1] | samp_q[0]) & rxs_q);
  assign data_w = shift_q >> (8 - DATA_BITS);
  assign deliver = mid && state_q == S_STOP;
  assign load = deliver && (!rx_valid_q || bus.rx_ready);

  always_comb begin
    state_d = state_q;
    bit_d = bit_q;
    shift_d = shift_q;
    par_d = par_q;
    s_d = state_q == S_IDLE ? 4'd0 : tick ? s_nxt : s_q;
    samp_d = win ? {samp_q[0], rxs_q} : samp_q;
    unique case (state_q)
      S_IDLE: state_d = rxs_q ? S_IDLE : S_START;
      S_START: begin
        bit_d = '0;
        state_d = (mid && maj) ? S_IDLE : last ? S_DATA : S_START;
      end
      S_DATA: begin
        shift_d = mid ? {maj, shift_q[7:1]} : shift_q;
        bit_d = last ? bit_q + 3'd1 : bit_q;
        if (last && bit_q == 3'(DATA_BITS - 1)) state_d = PARITY_EN != 0 ? S_PARITY : S_STOP;
      end
      S_PARITY: begin
        par_d = mid ? (((^data_w) ^ maj) != 1'(PARITY_ODD)) : par_q;
        state_d = last ? S_STOP : S_PARITY;
      end
      S_STOP: state_d = mid ? (maj ? S_IDLE : S_WAIT) : S_STOP;
      S_WAIT: state_d = rxs_q ? S_IDLE : S_WAIT;
      default: state_d = S_IDLE;
    endcase
    rx_data_d = load ? data_w : rx_data_q;
    frame_err_d = load ? !maj : frame_err_q;
    parity_err_d = load ? par_q : parity_err_q;
    rx_valid_d = load || (rx_valid_q && !bus.rx_ready);
    overrun_d = deliver && rx_valid_q && !bus.rx_ready;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      {meta_q, rxs_q} <= 2'b11;
      state_q <= S_IDLE;
      s_q <= '0;
      bit_q <= '0;
      samp_q <= '0;
      shift_q <= '0;
      par_q <= 1'b0;
      rx_data_q <= '0;
      rx_valid_q <= 1'b0;
      frame_err_q <= 1'b0;
      parity_err_q <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      {meta_q, rxs_q} <= {bus.rx, meta_q};
      state_q <= state_d;
      s_q <= s_d;
      bit_q <= bit_d;
      samp_q <= samp_d;
      shift_q <= shift_d;
      par_q <= par_d;
      rx_data_q <= rx_data_d;
      rx_valid_q <= rx_valid_d;
      frame_err_q <= frame_err_d;
      parity_err_q <= parity_err_d;
      overrun_q <= overrun_d;
    end
  end

  assign bus.rx_data = rx_data_q;
  assign bus.rx_valid = rx_valid_q;
  assign bus.frame_err = frame_err_q;
  assign bus.parity_err = parity_err_q;
  assign bus.overrun = overrun_q;
  assign bus.busy = state_q != S_IDLE;
endmodule
